// File: rtl/mux4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and mux4_rr_arbiter.
// master = arbiter side, slave = requester/mux side.
interface mux4_rr_arbiter_if;
   logic [3:0] req;
   logic       done;
   logic [3:0] gnt;
   logic       s0;
   logic       s1;
   logic       busy;
   logic       timeout;

   modport master (
      input  req, done,
      output gnt, s0, s1, busy, timeout
   );

   modport slave (
      output req, done,
      input  gnt, s0, s1, busy, timeout
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the s1/s0 selects of a 4-way mux, with a one-cycle dead gap
// between grants. Define ARB_TIMEOUT_EN to bound each grant to MAX_HOLD cycles.
module mux4_rr_arbiter #(
   parameter logic [1:0] RESET_PTR = 2'd3,
   parameter int         CNT_W     = 4,
   parameter int         MAX_HOLD  = 15
) (
   input logic               clk,
   input logic               rst_n,
   mux4_rr_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t     state_reg, state_next;
   logic [1:0] ptr_reg, ptr_next;
   logic [1:0] sel_reg, sel_next;
   logic [3:0] gnt_reg, gnt_next;
   logic       timeout_reg, timeout_next;

   logic [3:0] req_rot;
   logic [1:0] win;
   logic       any_req;
   logic       rel_norm;
   logic       hold_limit;

   // req_rot[0] is the requester just after the last-granted one, i.e. highest priority.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rot
         logic [1:0] idx;
         assign idx         = ptr_reg + 2'(gi + 1);
         assign req_rot[gi] = bus.req[idx];
      end
   endgenerate

   assign any_req = |bus.req;

   always_comb begin
      win = ptr_reg + 2'd1;
      for (int k = 3; k >= 0; k--) begin
         if (req_rot[k]) begin
            win = ptr_reg + 2'(k + 1);
         end
      end
   end

   // sel_reg holds the granted index for the whole grant.
   assign rel_norm = bus.done || !bus.req[sel_reg];

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   assign hold_limit = (cnt_reg == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      cnt_next = '0;
      if (state_reg == GRANT) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^{32'(CNT_W), 32'(MAX_HOLD)};
   assign hold_limit = 1'b0;
`endif

   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      sel_next     = sel_reg;
      gnt_next     = gnt_reg;
      timeout_next = 1'b0;
      case (state_reg)
         IDLE, GAP: begin
            if (any_req) begin
               state_next = GRANT;
               gnt_next   = 4'b0001 << win;
               sel_next   = win;
            end else begin
               state_next = IDLE;
               gnt_next   = 4'b0000;
            end
         end
         GRANT: begin
            if (rel_norm || hold_limit) begin
               state_next   = GAP;
               gnt_next     = 4'b0000;
               ptr_next     = sel_reg;
               timeout_next = hold_limit && !rel_norm;
            end
         end
         default: begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         ptr_reg     <= RESET_PTR;
         sel_reg     <= 2'b00;
         gnt_reg     <= 4'b0000;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         sel_reg     <= sel_next;
         gnt_reg     <= gnt_next;
         timeout_reg <= timeout_next;
      end
   end

   assign bus.gnt     = gnt_reg;
   assign bus.s0      = sel_reg[0];
   assign bus.s1      = sel_reg[1];
   assign bus.busy    = (state_reg == GRANT);
   assign bus.timeout = timeout_reg;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a behavioural model queues expected outputs per cycle,
// which are popped and compared one cycle later; directed scenarios plus a random phase.
module tb_mux4_rr_arbiter;
   localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux4_rr_arbiter_if bus();

   mux4_rr_arbiter #(
      .RESET_PTR (2'd3),
      .CNT_W     (4),
      .MAX_HOLD  (MAX_HOLD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
      logic       to;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // model state: 0 idle, 1 grant, 2 gap
   int         m_state = 0;
   int         m_cnt   = 0;
   logic [1:0] m_ptr   = 2'd3;
   logic [1:0] m_sel   = 2'd0;
   logic       m_to    = 1'b0;
   logic [3:0] prev_gnt = 4'b0000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model(input logic r, input logic [3:0] rq, input logic d);
      exp_t e;
      m_to = 1'b0;
      if (!r) begin
         m_state = 0;
         m_ptr   = 2'd3;
         m_sel   = 2'd0;
         m_cnt   = 0;
      end else if (m_state == 1) begin
         if (d || !rq[m_sel]) begin
            m_state = 2;
            m_ptr   = m_sel;
         end else if (TO_EN && m_cnt == MAX_HOLD - 1) begin
            m_state = 2;
            m_ptr   = m_sel;
            m_to    = 1'b1;
         end else begin
            m_cnt++;
         end
      end else begin
         m_state = 0;
         for (int k = 1; k <= 4; k++) begin
            int i;
            i = (int'(m_ptr) + k) % 4;
            if (rq[i]) begin
               m_state = 1;
               m_sel   = 2'(i);
               m_cnt   = 0;
               break;
            end
         end
      end
      e.gnt  = (m_state == 1) ? (4'b0001 << m_sel) : 4'b0000;
      e.sel  = m_sel;
      e.busy = (m_state == 1);
      e.to   = m_to;
      exp_q.push_back(e);
   endtask

   task automatic step(input logic r, input logic [3:0] rq, input logic d);
      exp_t e;
      rst_n    = r;
      bus.req  = rq;
      bus.done = d;
      model(r, rq, d);
      @(posedge clk);
      #1;
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("gnt", 32'(bus.gnt), 32'(e.gnt));
         check("sel", 32'({bus.s1, bus.s0}), 32'(e.sel));
         check("busy", 32'(bus.busy), 32'(e.busy));
         check("timeout", 32'(bus.timeout), 32'(e.to));
      end
      if (bus.gnt != 4'b0000 && prev_gnt == 4'b0000) begin
         $display("grant gnt=%b sel=%b%b t=%0t", bus.gnt, bus.s1, bus.s0, $time);
      end
      prev_gnt = bus.gnt;
   endtask

   initial begin
      logic [1:0] exp_order [5];
      logic [3:0] rq;
      exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      bus.req  = 4'b0000;
      bus.done = 1'b0;

      // reset with all requests pending
      step(1'b0, 4'b1111, 1'b0);
      step(1'b0, 4'b1111, 1'b0);
      check("t1_gnt", 32'(bus.gnt), 32'h0);

      // single requester, then done
      step(1'b1, 4'b0100, 1'b0);
      check("t2_gnt", 32'(bus.gnt), 32'b0100);
      check("t2_sel", 32'({bus.s1, bus.s0}), 32'd2);
      step(1'b1, 4'b0100, 1'b1);
      check("t2_sel_hold", 32'({bus.s1, bus.s0}), 32'd2);
      step(1'b1, 4'b0000, 1'b0);

      // full rotation with all requests held
      step(1'b0, 4'b0000, 1'b0);
      for (int g = 0; g < 5; g++) begin
         step(1'b1, 4'b1111, 1'b0);
         check("t3_order", 32'({bus.s1, bus.s0}), 32'(exp_order[g]));
         step(1'b1, 4'b1111, 1'b1);
         check("t3_gap", 32'(bus.gnt), 32'h0);
      end

      // ptr=1 after serving req[1]; then 1010 goes to req[3] first
      step(1'b0, 4'b0000, 1'b0);
      step(1'b1, 4'b0010, 1'b0);
      step(1'b1, 4'b0010, 1'b1);
      step(1'b1, 4'b1010, 1'b0);
      check("t4_first", 32'({bus.s1, bus.s0}), 32'd3);
      step(1'b1, 4'b1010, 1'b1);
      step(1'b1, 4'b1010, 1'b0);
      check("t4_second", 32'({bus.s1, bus.s0}), 32'd1);
      step(1'b1, 4'b0000, 1'b0);

      // hold limit with two requesters and no done
      step(1'b0, 4'b0000, 1'b0);
      for (int c = 0; c < 4; c++) step(1'b1, 4'b0011, 1'b0);
      step(1'b1, 4'b0011, 1'b0);
`ifdef ARB_TIMEOUT_EN
      check("t5_timeout", 32'(bus.timeout), 32'd1);
`else
      check("t5_unbounded", 32'(bus.gnt), 32'b0001);
`endif
      step(1'b1, 4'b0011, 1'b0);
`ifdef ARB_TIMEOUT_EN
      check("t5_next_sel", 32'({bus.s1, bus.s0}), 32'd1);
`endif
      step(1'b1, 4'b0000, 1'b0);
      step(1'b1, 4'b0000, 1'b0);

      // reset in the middle of a grant
      step(1'b0, 4'b0000, 1'b0);
      step(1'b1, 4'b0001, 1'b0);
      step(1'b1, 4'b0001, 1'b0);
      step(1'b0, 4'b0001, 1'b0);
      check("t6_reset_gnt", 32'(bus.gnt), 32'h0);
      step(1'b1, 4'b0001, 1'b0);
      check("t6_regrant", 32'(bus.gnt), 32'b0001);

      // random traffic
      rq = 4'b0000;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 2) == 0) rq = 4'($urandom_range(0, 15));
         step(($urandom_range(0, 99) != 0), rq, ($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
